// File: rtl/md_alu_sequencer.sv
// md_alu_sequencer
//   Multi-cycle MULTU/DIVU controller sharing the EX-stage 32-bit ALU.
//   Multiply is shift-add (ALU add), divide is restoring (ALU sub); one
//   ALU operation per cycle for ITER cycles. Owns the HI/LO registers and
//   stalls the pipeline through Busy while an operation is in flight.
//
//   Optional build macro: MD_SIGNED_EN
//     defined   : Signed=1 runs on operand magnitudes, then one FIX cycle
//                 applies the result signs (Done one cycle later).
//     undefined : Signed is ignored, all operations are unsigned.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   Start, Op, Signed request (sampled in IDLE), 0=mul 1=div, signed request
//   SrcA, SrcB        multiplier/dividend, multiplicand/divisor
//   AluCtl, AluShamt  ALU control (010 add, 110 sub), shift amount (always 0)
//   AluA, AluB        ALU operands, AluResult is the same-cycle ALU result
//   Busy, Done        stall request, one-cycle completion pulse
//   DivZero           divisor was zero, valid with Done
//   Hi, Lo            HI/LO result registers
module md_alu_sequencer #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic        Op,
  input  logic        Signed,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [2:0]  AluCtl,
  output logic [4:0]  AluShamt,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  input  logic [31:0] AluResult,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int unsigned CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

`ifdef MD_SIGNED_EN
  typedef enum logic [1:0] {IDLE, ITER_S, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER_S, DONE} state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   hi, hi_n, lo, lo_n, opnd, opnd_n;
  logic          op_r, op_n;
  logic [31:0]   rem_sh;
  logic          ok;

`ifdef MD_SIGNED_EN
  logic sgn, sgn_n, sa, sa_n, sb, sb_n;
`else
  logic unused_signed;
  assign unused_signed = Signed;
`endif

  assign rem_sh   = {hi[30:0], lo[31]};
  assign AluShamt = '0;
  assign Hi       = hi;
  assign Lo       = lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      op_r  <= 1'b0;
`ifdef MD_SIGNED_EN
      sgn   <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      opnd  <= opnd_n;
      op_r  <= op_n;
`ifdef MD_SIGNED_EN
      sgn   <= sgn_n;
      sa    <= sa_n;
      sb    <= sb_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    opnd_n  = opnd;
    op_n    = op_r;
    AluCtl  = '0;
    AluA    = '0;
    AluB    = '0;
    Busy    = 1'b0;
    Done    = 1'b0;
    DivZero = 1'b0;
    ok      = 1'b0;
`ifdef MD_SIGNED_EN
    sgn_n   = sgn;
    sa_n    = sa;
    sb_n    = sb;
`endif
    case (state)
      IDLE: begin
        if (Start) begin
          op_n    = Op;
          opnd_n  = SrcB;
          hi_n    = '0;
          lo_n    = SrcA;
          cnt_n   = '0;
          state_n = ITER_S;
`ifdef MD_SIGNED_EN
          sgn_n = Signed;
          sa_n  = Signed & SrcA[31];
          sb_n  = Signed & SrcB[31];
          if (Signed & SrcA[31]) lo_n   = -SrcA;
          if (Signed & SrcB[31]) opnd_n = -SrcB;
`endif
        end
      end
      ITER_S: begin
        Busy  = 1'b1;
        cnt_n = cnt + 1'b1;
        if (!op_r) begin
          // Shift-add: carry out of Hi+addend becomes the new Hi MSB.
          AluCtl = 3'b010;
          AluA   = hi;
          AluB   = lo[0] ? opnd : '0;
          hi_n   = {(AluResult < hi), AluResult[31:1]};
          lo_n   = {AluResult[0], lo[31:1]};
        end else begin
          // Restoring divide on the 33-bit partial remainder {Hi[31], R}.
          AluCtl = 3'b110;
          AluA   = rem_sh;
          AluB   = opnd;
          ok     = hi[31] | ~(AluResult > rem_sh);
          hi_n   = ok ? AluResult : rem_sh;
          lo_n   = {lo[30:0], ok};
        end
        if (cnt == LAST) begin
`ifdef MD_SIGNED_EN
          state_n = sgn ? FIX : DONE;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef MD_SIGNED_EN
      FIX: begin
        Busy    = 1'b1;
        state_n = DONE;
        if (!op_r) begin
          if (sa ^ sb) {hi_n, lo_n} = -{hi, lo};
        end else begin
          // Divide by zero leaves Lo all-ones; negating Hi when sa restores
          // the original SrcA from its magnitude.
          if ((sa ^ sb) && (opnd != '0)) lo_n = -lo;
          if (sa) hi_n = -hi;
        end
      end
`endif
      DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        DivZero = op_r & (opnd == '0);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_alu_sequencer.sv
module tb_md_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst, Start, Op, Signed;
  logic [31:0] SrcA, SrcB, AluA, AluB, AluResult, Hi, Lo;
  logic [2:0]  AluCtl;
  logic [4:0]  AluShamt;
  logic        Busy, Done, DivZero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Combinational shared ALU.
  assign AluResult = (AluCtl == 3'b010) ? AluA + AluB :
                     (AluCtl == 3'b110) ? AluA - AluB : 32'h0;

  md_alu_sequencer #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .Signed(Signed),
    .SrcA(SrcA), .SrcB(SrcB), .AluCtl(AluCtl), .AluShamt(AluShamt),
    .AluA(AluA), .AluB(AluB), .AluResult(AluResult), .Busy(Busy),
    .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sgn_eff(input logic s);
`ifdef MD_SIGNED_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain arithmetic on whole operands.
  function automatic void model(input logic op, input logic s, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] eh,
                                output logic [31:0] el, output logic edz);
    longint sa_v, sb_v, q, r;
    logic [63:0] p;
    sa_v = longint'(signed'(a));
    sb_v = longint'(signed'(b));
    edz  = op && (b == 32'h0);
    if (!op) begin
      if (sgn_eff(s)) p = 64'(sa_v * sb_v);
      else            p = 64'(a) * 64'(b);
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'h0) begin
      eh = a;
      el = 32'hFFFFFFFF;
    end else if (sgn_eff(s)) begin
      q  = sa_v / sb_v;
      r  = sa_v % sb_v;
      el = q[31:0];
      eh = r[31:0];
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  // Issue one operation and follow it cycle by cycle to one cycle past Done.
  // pulse_k > 0 drives a stray Start in that cycle after acceptance.
  task automatic run_op(input string nm, input logic op, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input int pulse_k,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int lat, bad_busy, bad_alu, bad_dz;
    logic [2:0] ectl;
    lat = (sgn_eff(s)) ? 34 : 33;
    bad_busy = 0; bad_alu = 0; bad_dz = 0;
    @(negedge clk);
    Start = 1'b1; Op = op; Signed = s; SrcA = a; SrcB = b;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      ectl = (k <= 32) ? (op ? 3'b110 : 3'b010) : 3'b000;
      if (AluCtl !== ectl || AluShamt !== 5'd0) bad_alu++;
      if (k > 32 && (AluA !== 32'h0 || AluB !== 32'h0)) bad_alu++;
      if (k <= lat) begin
        if (Busy !== 1'b1 || Done !== (k == lat)) bad_busy++;
      end
      if (k < lat && DivZero !== 1'b0) bad_dz++;
      if (k == lat) begin
        check({nm, "_hi"}, 64'(Hi), 64'(eh));
        check({nm, "_lo"}, 64'(Lo), 64'(el));
        check({nm, "_dz"}, 64'(DivZero), 64'(edz));
      end
      if (k == lat + 1) begin
        check({nm, "_idle"}, {61'h0, Busy, Done, DivZero}, 64'h0);
        check({nm, "_hold"}, {Hi, Lo}, {eh, el});
      end
      if (k == 1) begin
        Start = 1'b0; SrcA = $urandom; SrcB = $urandom; Op = ~op;
      end
      if (k == pulse_k) begin
        Start = 1'b1; SrcA = $urandom; SrcB = $urandom;
      end else if (k == pulse_k + 1) begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    check({nm, "_busyseq"}, 64'(bad_busy), 64'h0);
    check({nm, "_aluctl"}, 64'(bad_alu), 64'h0);
    check({nm, "_dzlow"}, 64'(bad_dz), 64'h0);
  endtask

  typedef struct {
    string       nm;
    logic        op;
    logic        s;
    logic [31:0] a, b, eh, el;
    logic        edz;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] ra, rb, eh, el;
    logic rop, rs, edz;

    vecs.push_back('{"mul7x6",   1'b0, 1'b0, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0});
    vecs.push_back('{"mulmax",   1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0});
    vecs.push_back('{"div100_7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
    vecs.push_back('{"divzero",  1'b1, 1'b0, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"mul0",     1'b0, 1'b0, 32'h0, 32'd5, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{"div5_9",   1'b1, 1'b0, 32'd5, 32'd9, 32'd5, 32'h0, 1'b0});
    vecs.push_back('{"divmax_1", 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"mulmsb",   1'b0, 1'b0, 32'h80000000, 32'd2, 32'h1, 32'h0, 1'b0});
`ifdef MD_SIGNED_EN
    vecs.push_back('{"smul",     1'b0, 1'b1, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{"sdiv",     1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{"sdivzero", 1'b1, 1'b1, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1});
`else
    vecs.push_back('{"signore",  1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 1'b0});
`endif

    rst = 1'b1; Start = 1'b0; Op = 1'b0; Signed = 1'b0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", {61'h0, Busy, Done, DivZero}, 64'h0);
    check("reset_hilo", {Hi, Lo}, 64'h0);
    check("reset_alu", {AluCtl, AluShamt, AluA, AluB}, 72'h0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].op, vecs[i].s, vecs[i].a, vecs[i].b, 0,
             vecs[i].eh, vecs[i].el, vecs[i].edz);

    // Stray Start mid-ITER and in DONE must be ignored.
    run_op("start_iter", 1'b0, 1'b0, 32'd7, 32'd6, 5, 32'h0, 32'd42, 1'b0);
    run_op("start_done", 1'b1, 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);

    // Reset at iteration 10 aborts the operation.
    @(negedge clk);
    Start = 1'b1; Op = 1'b0; Signed = 1'b0; SrcA = 32'd7; SrcB = 32'd6;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst_busy_pre", 64'(Busy), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags", {61'h0, Busy, Done, DivZero}, 64'h0);
    check("midrst_hilo", {Hi, Lo}, 64'h0);
    rst = 1'b0;
    run_op("after_rst", 1'b0, 1'b0, 32'd3, 32'd5, 0, 32'h0, 32'd15, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      rop = 1'($urandom);
      rs  = 1'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 20);
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      model(rop, rs, ra, rb, eh, el, edz);
      run_op("rand", rop, rs, ra, rb, 0, eh, el, edz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_alu_sequencer.md
Name: md_alu_sequencer

Overview:
- Multi-cycle MULTU/DIVU controller that drives the shared 32-bit ALU. It issues one ALU operation per cycle: add for shift-add multiply, sub for restoring divide.
- Sits in EX beside the ALU and owns the HI/LO result registers.
- Holds the pipeline stalled via Busy while an operation runs.

Parameters:
- ITER, 32, number of iteration cycles (equals operand width; fixed at 32 for this core).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request a new operation; sampled only in IDLE.
- Op  input  1  0 = multiply, 1 = divide.
- Signed  input  1  signed operation; honoured only with MD_SIGNED_EN.
- SrcA  input  32  multiplier / dividend.
- SrcB  input  32  multiplicand / divisor.
- AluCtl  output  3  ALU control code: 010 = add, 110 = sub.
- AluShamt  output  5  ALU shift amount; always 0.
- AluA  output  32  ALU operand A.
- AluB  output  32  ALU operand B.
- AluResult  input  32  combinational ALU result, same cycle.
- Busy  output  1  operation in progress; pipeline stall request.
- Done  output  1  one-cycle completion pulse.
- DivZero  output  1  divisor was 0; valid while Done=1.
- Hi  output  32  HI register (product upper word / remainder).
- Lo  output  32  LO register (product lower word / quotient).

Behaviour:
- Reset: state IDLE; Hi=Lo=0; Busy=Done=DivZero=0; counter=0.
- Reset takes priority in every state, including mid-ITER. The operation is aborted and the partial result discarded.
- ALU drive: AluCtl, AluA and AluB are combinational from registered state. They are 0/000 outside ITER.
- FSM states: IDLE, ITER, (FIX), DONE.
- IDLE:
  - Start=1 captures SrcB into an operand register.
  - Loads Hi=0, Lo=SrcA, counter=0; goes to ITER.
  - Start=0 holds all registers.
- ITER: exactly 32 cycles. Busy=1. Counter increments each cycle. After counter=31, goes to DONE (or FIX).
- Multiply step:
  - AluCtl=010, AluA=Hi, AluB = Lo[0] ? Opnd : 0.
  - carry = (AluResult < AluA), unsigned compare.
  - Hi <= {carry, AluResult[31:1]}; Lo <= {AluResult[0], Lo[31:1]}.
  - Final {Hi,Lo} is the 64-bit unsigned product.
- Divide step:
  - R = {Hi[30:0], Lo[31]}; msb = Hi[31].
  - AluCtl=110, AluA=R, AluB=Opnd.
  - borrow = (AluResult > AluA), unsigned; ok = msb | ~borrow.
  - Hi <= ok ? AluResult : R; Lo <= {Lo[30:0], ok}.
  - Final Lo = quotient, Hi = remainder.
- DONE: one cycle. Done=1, Busy=1. DivZero = Op & (Opnd==0). Next state IDLE.
- Divide by zero runs the full 32 iterations with no special-casing. It yields Lo=32'hFFFFFFFF, Hi=SrcA, and DivZero=1 in DONE.
- Latency: Start accepted at cycle N; Busy=1 in N+1..N+33; Done=1 at N+33; Hi/Lo final at N+33.
- Start while Busy=1, including in DONE, is ignored and not queued.
- Hi/Lo hold their values until the next accepted Start or rst.
- Operands are captured at accept. SrcA/SrcB changes during ITER have no effect.

Optional Feature:
- Macro: MD_SIGNED_EN.
- Defined, accept with Signed=1:
  - Operands are converted to magnitudes at accept.
  - Sign flags are recorded: sa = SrcA[31], sb = SrcB[31].
  - After ITER, one FIX cycle (Busy=1) applies the signs.
  - Multiply: if sa^sb, {Hi,Lo} is 64-bit two's-complement negated.
  - Divide: Lo is negated if sa^sb; Hi is negated if sa.
  - Divide by zero skips the fixup: Hi=SrcA, Lo=FFFFFFFF.
  - Negation is done by internal logic, not the ALU.
  - Done at N+34.
  - Signed=0 behaves as unsigned with no FIX cycle (Done at N+33).
- Undefined: no FIX state; Signed is ignored; all operations unsigned; Done at N+33.

Test Plan:
- Mult 7 × 6: Start at N -> Busy N+1..N+33, Done pulse at N+33, Hi=0, Lo=42, DivZero=0.
- Mult FFFFFFFF × FFFFFFFF (carry path) -> Hi=FFFFFFFE, Lo=00000001.
- Div 100 / 7 -> Lo=14, Hi=2. Check AluCtl=110 on every ITER cycle and AluShamt=0 throughout.
- Div 0x1234 / 0 -> Lo=FFFFFFFF, Hi=00001234, DivZero=1 during Done only.
- Start pulsed during ITER is ignored. rst at iteration 10 -> next cycle Busy=0, Hi=Lo=0, state IDLE. A following mult 3 × 5 yields Lo=15.
- With MD_SIGNED_EN:
  - Signed mult -7 × 3 -> Hi=FFFFFFFF, Lo=FFFFFFEB, Done at N+34.
  - Signed div -7 / 2 -> Lo=FFFFFFFD, Hi=FFFFFFFF.
